// File: rtl/stream_lfsr_checker.sv
// Checks a 32-bit LFSR data stream, counting accepted beats and mismatches.
// Optional ready stall pattern: define STREAM_LFSR_CHECKER_STALL_EN.
module stream_lfsr_checker #(
  parameter bit ResyncOnError = 1'b1,
  parameter int ErrCntWidth   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [31:0]            data_i,
  output logic                   synced_o,
  output logic                   err_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic [31:0]            beat_cnt_o
);

  typedef enum logic {
    SYNC  = 1'b0,
    CHECK = 1'b1
  } state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'hA300_0000 : 32'h0000_0000);
  endfunction

  state_e                 r_state;
  logic [31:0]            r_expected;
  logic [31:0]            r_beat_cnt;
  logic [ErrCntWidth-1:0] r_err_cnt;
  logic                   r_err;
  logic                   w_stall;
  logic                   w_accept;
  logic                   w_mismatch;

`ifdef STREAM_LFSR_CHECKER_STALL_EN
  // x^8+x^6+x^5+x^4+1, free-running; only reset stops it
  logic [7:0] r_stall_lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_lfsr <= 8'h01;
    end else begin
      r_stall_lfsr <= {r_stall_lfsr[6:0],
                       r_stall_lfsr[7] ^ r_stall_lfsr[5] ^ r_stall_lfsr[4] ^ r_stall_lfsr[3]};
    end
  end

  assign w_stall = (r_stall_lfsr[2:0] == 3'b000);
`else
  assign w_stall = 1'b0;
`endif

  assign ready_o  = rst_ni & ~clear_i & ~w_stall;
  assign w_accept = valid_i & ready_o;

  // In SYNC only the lock-up value is an error; in CHECK any deviation is.
  assign w_mismatch = (r_state == SYNC) ? (data_i == '0) : (data_i != r_expected);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= SYNC;
      r_expected <= '0;
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
      r_err      <= 1'b0;
    end else if (clear_i) begin
      r_state    <= SYNC;
      r_expected <= '0;
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        r_err <= w_mismatch;
        if (r_beat_cnt != '1) begin
          r_beat_cnt <= r_beat_cnt + 32'd1;
        end
        if (w_mismatch && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + ErrCntWidth'(1);
        end
        if (r_state == SYNC) begin
          if (data_i != '0) begin
            r_expected <= lfsr_next(data_i);
            r_state    <= CHECK;
          end
        end else if (!w_mismatch) begin
          r_expected <= lfsr_next(r_expected);
        end else begin
          r_expected <= ResyncOnError ? lfsr_next(data_i) : lfsr_next(r_expected);
          if (data_i == '0) begin
            r_state <= SYNC;
          end
        end
      end
    end
  end

  assign synced_o   = (r_state == CHECK);
  assign err_o      = r_err;
  assign err_cnt_o  = r_err_cnt;
  assign beat_cnt_o = r_beat_cnt;

endmodule

// File: tb/tb_stream_lfsr_checker.sv
// Bench for stream_lfsr_checker: directed steps plus randomized beats against a reference model.
// Two instances: defaults, and ResyncOnError=0 with a 2-bit error counter.
module tb_stream_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        clear_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] data_i = '0;

  logic        ready_a, synced_a, err_a;
  logic [15:0] errc_a;
  logic [31:0] beat_a;
  logic        ready_b, synced_b, err_b;
  logic [1:0]  errc_b;
  logic [31:0] beat_b;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    bit                synced;
    logic [31:0]       exp;
    longint unsigned   errs;
    longint unsigned   beats;
    bit                err;
  } model_t;

  model_t     ma, mb;
  logic [7:0] stall_m = 8'h01;

  always #5 clk = ~clk;

  stream_lfsr_checker dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
    .ready_o(ready_a), .data_i(data_i), .synced_o(synced_a), .err_o(err_a),
    .err_cnt_o(errc_a), .beat_cnt_o(beat_a)
  );

  stream_lfsr_checker #(.ResyncOnError(1'b0), .ErrCntWidth(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
    .ready_o(ready_b), .data_i(data_i), .synced_o(synced_b), .err_o(err_b),
    .err_cnt_o(errc_b), .beat_cnt_o(beat_b)
  );

  function automatic logic [31:0] nxt(input logic [31:0] x);
    return (x / 2) ^ ((x % 2 == 1) ? 32'hA300_0000 : 32'h0);
  endfunction

  function automatic longint unsigned sat(input longint unsigned v, input longint unsigned m);
    return (v > m) ? m : v;
  endfunction

  function automatic model_t mreset();
    model_t m;
    m.synced = 1'b0; m.exp = '0; m.errs = 0; m.beats = 0; m.err = 1'b0;
    return m;
  endfunction

  function automatic model_t mstep(input model_t m0, input bit resync, input logic [31:0] d);
    model_t m = m0;
    m.beats = m.beats + 1;
    m.err = 1'b0;
    if (!m.synced) begin
      if (d == 0) begin
        m.err = 1'b1;
      end else begin
        m.synced = 1'b1;
        m.exp = nxt(d);
      end
    end else if (d == m.exp) begin
      m.exp = nxt(m.exp);
    end else begin
      m.err = 1'b1;
      m.exp = resync ? nxt(d) : nxt(m.exp);
      if (d == 0) m.synced = 1'b0;
    end
    if (m.err) m.errs = m.errs + 1;
    return m;
  endfunction

  function automatic bit stalled(input logic [7:0] s);
`ifdef STREAM_LFSR_CHECKER_STALL_EN
    return (s % 8) == 0;
`else
    return (s != s);
`endif
  endfunction

  function automatic logic [7:0] stall_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("synced_a", {63'd0, synced_a}, {63'd0, ma.synced});
    chk("err_a", {63'd0, err_a}, {63'd0, ma.err});
    chk("errcnt_a", {48'd0, errc_a}, sat(ma.errs, 64'd65535));
    chk("beatcnt_a", {32'd0, beat_a}, sat(ma.beats, 64'hFFFF_FFFF));
    chk("synced_b", {63'd0, synced_b}, {63'd0, mb.synced});
    chk("err_b", {63'd0, err_b}, {63'd0, mb.err});
    chk("errcnt_b", {62'd0, errc_b}, sat(mb.errs, 64'd3));
    chk("beatcnt_b", {32'd0, beat_b}, sat(mb.beats, 64'hFFFF_FFFF));
  endtask

  // One clock cycle of stimulus: drive at negedge, model and check after posedge.
  task automatic cycle(input bit v, input logic [31:0] d, input bit c);
    bit rdy;
    @(negedge clk);
    valid_i = v; data_i = d; clear_i = c;
    #1;
    rdy = rst_ni && !c && !stalled(stall_m);
    chk("ready_a", {63'd0, ready_a}, {63'd0, rdy});
    chk("ready_b", {63'd0, ready_b}, {63'd0, rdy});
    @(posedge clk);
    if (c) begin
      ma = mreset(); mb = mreset();
    end else if (v && rdy) begin
      ma = mstep(ma, 1'b1, d); mb = mstep(mb, 1'b0, d);
    end else begin
      ma.err = 1'b0; mb.err = 1'b0;
    end
    stall_m = stall_next(stall_m);
    #1;
    check_outputs();
  endtask

  // Asserts reset mid-cycle with the given beat on the bus; releases just after a posedge.
  task automatic do_reset(input bit v, input logic [31:0] d);
    @(negedge clk);
    valid_i = v; data_i = d; clear_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    ma = mreset(); mb = mreset(); stall_m = 8'h01;
    chk("rst_ready_a", {63'd0, ready_a}, 64'd0);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_ni = 1'b1;
    valid_i = 1'b0;
  endtask

  initial begin
    int          pulses;
    int unsigned r;
    logic [31:0] d;

    ma = mreset(); mb = mreset();
    do_reset(1'b0, 32'h0);

    // Lock onto the canonical sequence
    cycle(1'b1, 32'h0000_0001, 1'b0);
    chk("lock_synced_first", {63'd0, synced_a}, 64'd1);
    cycle(1'b1, 32'hA300_0000, 1'b0);
    cycle(1'b1, 32'h5180_0000, 1'b0);
    chk("lock_beats", {32'd0, beat_a}, 64'd3);
    chk("lock_errs", {48'd0, errc_a}, 64'd0);

    // Mismatch then resync
    cycle(1'b1, 32'h1234_5678, 1'b0);
    chk("mm_pulse", {63'd0, err_a}, 64'd1);
    chk("mm_cnt", {48'd0, errc_a}, 64'd1);
    cycle(1'b1, 32'h091A_2B3C, 1'b0);
    chk("resync_noerr", {63'd0, err_a}, 64'd0);
    cycle(1'b1, ma.exp, 1'b0);
    cycle(1'b1, ma.exp, 1'b0);
    chk("resync_cnt", {48'd0, errc_a}, 64'd1);

    // Idle with valid low changes nothing
    cycle(1'b0, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);

    // Zero data in CHECK, then in SYNC
    cycle(1'b1, 32'h0, 1'b0);
    chk("zero_check_unsync", {63'd0, synced_a}, 64'd0);
    cycle(1'b1, 32'h0, 1'b0);
    chk("zero_sync_pulse", {63'd0, err_a}, 64'd1);
    chk("zero_sync_stay", {63'd0, synced_a}, 64'd0);

    // Relock, then clear collides with a valid beat
    cycle(1'b1, 32'hCAFE_F00D, 1'b0);
    cycle(1'b1, ma.exp, 1'b0);
    cycle(1'b1, ma.exp, 1'b1);
    chk("clear_synced", {63'd0, synced_a}, 64'd0);
    chk("clear_beats", {32'd0, beat_a}, 64'd0);
    chk("clear_errs", {48'd0, errc_a}, 64'd0);

    // Saturation on the 2-bit counter instance
    cycle(1'b1, 32'h0000_0001, 1'b0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, mb.exp ^ 32'h1, 1'b0);
      if (err_b) pulses++;
    end
    chk("sat_pulses", 64'(pulses), 64'd5);
    chk("sat_errcnt", {62'd0, errc_b}, 64'd3);

    // Held-valid in-sequence run
    cycle(1'b1, 32'h1357_9BDF, 1'b1);
    cycle(1'b1, 32'h1357_9BDF, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, ma.exp, 1'b0);
    end
    chk("held_no_errs", {48'd0, errc_a}, 64'd0);

    // Randomized mix of good, bad, zero beats, valid gaps and occasional clears
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      d = ma.synced ? ma.exp : ($urandom | 32'h1);
      else if (r < 85) d = $urandom;
      else if (r < 92) d = 32'h0;
      else             d = mb.exp;
      cycle($urandom_range(0, 9) != 0, d, $urandom_range(0, 49) == 0);
    end

    // Reset while a beat is on the bus drops it
    do_reset(1'b1, ma.exp);
    chk("rst_mid_beats", {32'd0, beat_a}, 64'd0);
    cycle(1'b1, 32'h0000_0001, 1'b0);
    chk("post_rst_beat", {32'd0, beat_a}, 64'd1);
    cycle(1'b1, ma.exp, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_lfsr_checker.md
STREAM_LFSR_CHECKER -- requirements
Module: stream_lfsr_checker

Interface
REQ-001 Parameter ResyncOnError, bit, default 1: on mismatch, reload the expected value from the received data.
REQ-002 Parameter ErrCntWidth, int, default 16: width of the error counter, minimum 1.
REQ-003 clk_i  input  1  clock; all state is updated on its rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 clear_i  input  1  synchronous clear with the same effect as reset.
REQ-006 valid_i  input  1  input stream valid.
REQ-007 ready_o  output  1  input stream ready.
REQ-008 data_i  input  32  input stream data, expected to be an LFSR sequence.
REQ-009 synced_o  output  1  checker is locked onto the sequence.
REQ-010 err_o  output  1  one-cycle pulse per mismatching beat.
REQ-011 err_cnt_o  output  ErrCntWidth  saturating mismatch count.
REQ-012 beat_cnt_o  output  32  saturating count of accepted beats.

Function
REQ-013 A beat SHALL be accepted only in a cycle where valid_i=1 and ready_o=1.
REQ-014 LFSR step SHALL be next(x) = (x>>1) XOR (x[0] ? 32'hA3000000 : 0), computed at 32-bit width.
REQ-015 FSM SHALL have two states: SYNC (reset state) and CHECK.
REQ-016 SYNC, accepted beat, data_i!=0: expected <= next(data_i); state -> CHECK; no error is reported.
REQ-017 SYNC, accepted beat, data_i==0 (LFSR lock-up value): stay in SYNC; err_o pulses; err_cnt increments.
REQ-018 CHECK, accepted beat, data_i==expected: expected <= next(expected); no error is reported.
REQ-019 CHECK mismatch: err_o pulses; err_cnt increments; expected <= next(data_i) if ResyncOnError=1, else next(expected); state stays CHECK.
REQ-020 CHECK mismatch with data_i==0: state SHALL return to SYNC regardless of ResyncOnError.
REQ-021 err_o, err_cnt_o, beat_cnt_o and synced_o SHALL be registered and reflect a beat in the cycle after its handshake (latency 1).
REQ-022 synced_o SHALL be 1 exactly when the state is CHECK.
REQ-023 beat_cnt SHALL increment on every accepted beat, including erroneous ones, and saturate at 32'hFFFFFFFF.
REQ-024 err_cnt SHALL saturate at all-ones; a mismatch at saturation still pulses err_o.
REQ-025 ready_o SHALL be 0 while clear_i=1, so a beat is never accepted in a clear cycle (clear wins over a simultaneous beat).
REQ-026 clear_i=1 SHALL, at the next edge: state <= SYNC; expected, err_cnt and beat_cnt <= 0; err_o <= 0.
REQ-027 Holding valid_i=1 with ready_o=0 SHALL NOT change any state.

Reset
REQ-028 On rst_ni=0, asynchronously: state=SYNC, expected=0, synced_o=0, err_o=0, err_cnt_o=0, beat_cnt_o=0.
REQ-029 ready_o SHALL be 0 while rst_ni=0 and SHALL be 1 in the first cycle after release, subject to REQ-031.
REQ-030 Reset asserted mid-stream SHALL drop the in-flight beat without counting it.

Configuration
REQ-031 Macro STREAM_LFSR_CHECKER_STALL_EN defined: an internal 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset 8'h01) advances every cycle, and ready_o=0 whenever its bits [2:0]==0, in addition to REQ-025.
REQ-032 STREAM_LFSR_CHECKER_STALL_EN undefined: no stall LFSR is present, and ready_o = rst-released AND NOT clear_i.

Verification
REQ-033 Lock: after reset, beats 32'h00000001, 32'hA3000000, 32'h51800000 -> synced_o=1 after first beat, err_cnt_o=0, beat_cnt_o=3.
REQ-034 Mismatch and resync: in CHECK, send 32'h12345678 instead of the expected 32'h28C00000, then next(32'h12345678) -> one err_o pulse, err_cnt_o=1, then no further errors with ResyncOnError=1.
REQ-035 Zero data: beat 32'h00000000 in SYNC -> err_o pulse, synced_o stays 0; the same beat in CHECK -> return to SYNC.
REQ-036 Clear collision: clear_i=1 with valid_i=1 in CHECK -> ready_o=0, beat not counted, next cycle synced_o=0 and counters=0.
REQ-037 Saturation: with ErrCntWidth=2, send 5 mismatching beats -> err_cnt_o=3 and 5 err_o pulses.
REQ-038 Stall build: with STREAM_LFSR_CHECKER_STALL_EN defined and valid_i=1 held -> ready_o low exactly when the stall LFSR bits [2:0]==0, and beats stay in sequence without errors.
